// File: rtl/tt_pkg.sv
// -----------------------------------------------------------------------------
// tt_pkg
// Shared definitions for the truth_table_sweeper block:
//   - tt_state_e   : sweep FSM state encoding (IDLE/DRIVE/PAUSE/DONE)
//   - tt_clog2()   : ceiling log2 helper used for counter sizing
//   - N_IN/N_OUT legal-range limits checked at elaboration by the top
// No ports (package).
// -----------------------------------------------------------------------------
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } tt_state_e;

    localparam int N_IN_MIN  = 1;
    localparam int N_IN_MAX  = 8;
    localparam int N_OUT_MIN = 1;
    localparam int N_OUT_MAX = 8;

    // Smallest r with 2**r >= value; tt_clog2(1) == 0.
    function automatic int tt_clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
// Groups the sweeper's control, DUT stimulus/response and result signals.
//   start, step_mode, step : sweep control from the controller
//   dut_out                : response of the combinational DUT
//   vec_out                : stimulus vector to the DUT
//   busy, done             : sweep status
//   table_out              : captured truth table, slot v at [v*N_OUT +: N_OUT]
// Optional (macro TT_CHECK_EN): expected_in golden table, mismatch, err_count.
// Modports: master = controller/DUT side, slave = the sweeper.
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 1
);
    localparam int TW = (1 << N_IN) * N_OUT;

    logic              start;
    logic              step_mode;
    logic              step;
    logic [N_OUT-1:0]  dut_out;
    logic [N_IN-1:0]   vec_out;
    logic              busy;
    logic              done;
    logic [TW-1:0]     table_out;
`ifdef TT_CHECK_EN
    logic [TW-1:0]     expected_in;
    logic              mismatch;
    logic [N_IN:0]     err_count;

    modport master (
        output start, step_mode, step, dut_out, expected_in,
        input  vec_out, busy, done, table_out, mismatch, err_count
    );
    modport slave (
        input  start, step_mode, step, dut_out, expected_in,
        output vec_out, busy, done, table_out, mismatch, err_count
    );
`else
    modport master (
        output start, step_mode, step, dut_out,
        input  vec_out, busy, done, table_out
    );
    modport slave (
        input  start, step_mode, step, dut_out,
        output vec_out, busy, done, table_out
    );
`endif

endinterface

// File: rtl/tt_hold_counter.sv
// -----------------------------------------------------------------------------
// tt_hold_counter
// Counts the clocks a vector has been held.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : synchronous clear to 0 (wins over en_i)
//   en_i     : increment
//   tc_o     : count has reached HOLD_CYCLES-1 (last hold clock)
// -----------------------------------------------------------------------------
module tt_hold_counter
    import tt_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = tt_clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] TC_VALUE = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: registers are written with non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VALUE);

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Drives every input vector 0..2^N_IN-1 onto a combinational DUT, holds each
// for HOLD_CYCLES clocks and captures the DUT response into table_out.
// Free-running or single-step (pause after each sample until step).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : truth_table_sweeper_if.slave (start, step_mode, step, dut_out,
//              vec_out, busy, done, table_out)
// Optional macro TT_CHECK_EN adds expected_in/mismatch/err_count: each sample
// is compared with the golden slot, err_count saturates at 2^N_IN.
// -----------------------------------------------------------------------------
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN        = 2,
    parameter int N_OUT       = 1,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_sweeper_if.slave  bus
);
    localparam int N_VEC = 1 << N_IN;
    localparam int TW    = N_VEC * N_OUT;
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(N_VEC - 1);

    if (N_IN < N_IN_MIN || N_IN > N_IN_MAX || N_OUT < N_OUT_MIN ||
        N_OUT > N_OUT_MAX || HOLD_CYCLES < 1) begin : g_bad_params
        $error("truth_table_sweeper: parameter out of legal range");
    end

    tt_state_e       state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [TW-1:0]   table_q, table_d;
    logic            step_mode_q, step_mode_d;
    logic            start_ok, sample, step_ok, advance;
    logic            cnt_clr, cnt_en, cnt_tc;
    logic            busy, done;

    tt_hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_counter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.start) state_d = DRIVE;
            DRIVE: begin
                if (cnt_tc) begin
                    if (vec_q == LAST_VEC) state_d = DONE;
                    else if (step_mode_q)  state_d = PAUSE;
                end
            end
            PAUSE:   if (bus.step) state_d = DRIVE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        busy     = (state_q == DRIVE) || (state_q == PAUSE);
        done     = (state_q == DONE);
        start_ok = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
        sample   = (state_q == DRIVE) && cnt_tc;
        step_ok  = (state_q == PAUSE) && bus.step;
        // Free-running advance happens on the sample clock itself.
        advance  = (sample && (vec_q != LAST_VEC) && !step_mode_q) || step_ok;
        cnt_clr  = start_ok || sample || step_ok;
        cnt_en   = (state_q == DRIVE);

        vec_d       = vec_q;
        table_d     = table_q;
        step_mode_d = step_mode_q;
        if (start_ok) begin
            vec_d       = '0;
            table_d     = '0;
            step_mode_d = bus.step_mode;
        end else begin
            for (int v = 0; v < N_VEC; v++) begin
                if (sample && (vec_q == N_IN'(v))) begin
                    table_d[v*N_OUT +: N_OUT] = bus.dut_out;
                end
            end
            if (advance) vec_d = vec_q + N_IN'(1);
        end
    end

    // NOTE: table_q is a flop array rather than a RAM, so it is reset along
    // with the rest of the state; an aborted sweep leaves no partial table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q       <= '0;
            table_q     <= '0;
            step_mode_q <= 1'b0;
        end else begin
            vec_q       <= vec_d;
            table_q     <= table_d;
            step_mode_q <= step_mode_d;
        end
    end

    assign bus.vec_out   = vec_q;
    assign bus.table_out = table_q;
    assign bus.busy      = busy;
    assign bus.done      = done;

`ifdef TT_CHECK_EN
    localparam logic [N_IN:0] ERR_MAX = (N_IN + 1)'(N_VEC);

    logic [N_IN:0]    err_q, err_d;
    logic [N_OUT-1:0] exp_slot;

    always_comb begin
        exp_slot = '0;
        for (int v = 0; v < N_VEC; v++) begin
            if (vec_q == N_IN'(v)) exp_slot = bus.expected_in[v*N_OUT +: N_OUT];
        end
        err_d = err_q;
        if (start_ok) begin
            err_d = '0;
        end else if (sample && (bus.dut_out != exp_slot) && (err_q != ERR_MAX)) begin
            err_d = err_q + (N_IN + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_count = err_q;
    assign bus.mismatch  = (err_q != '0);
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Two sweeper instances share one clock/reset:
//   u_a : N_IN=2, N_OUT=1, HOLD_CYCLES=10
//   u_b : N_IN=3, N_OUT=2, HOLD_CYCLES=1
// Each DUT-under-sweep is a lookup table (func_a / func_b) driven from
// vec_out. Expected outputs come from the sweep timing rules: after the start
// edge, vector v is on vec_out for cycles v*H .. (v+1)*H-1 and slot v is
// filled at cycle (v+1)*H.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(2), .N_OUT(1)) if_a ();
    truth_table_sweeper_if #(.N_IN(3), .N_OUT(2)) if_b ();

    truth_table_sweeper #(.N_IN(2), .N_OUT(1), .HOLD_CYCLES(10)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    truth_table_sweeper #(.N_IN(3), .N_OUT(2), .HOLD_CYCLES(1)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    logic [3:0]  func_a = 4'b1000;
    logic [15:0] func_b = '0;

    always_comb if_a.dut_out = func_a[if_a.vec_out];
    always_comb if_b.dut_out = func_b[{if_b.vec_out, 1'b0} +: 2];

    int errors = 0;
    int checks = 0;

    // Lower n_done slots (width w) of tbl, rest zero.
    function automatic logic [15:0] partial(input logic [15:0] tbl, input int n_done,
                                            input int w);
        logic [15:0] res;
        res = '0;
        for (int i = 0; i < n_done * w; i++) res[i] = tbl[i];
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({if_a.vec_out, if_a.busy, if_a.done, if_a.table_out} !== 8'h00) begin
            errors++;
            $display("FAIL reset_a: got %h expected 00",
                     {if_a.vec_out, if_a.busy, if_a.done, if_a.table_out});
        end
        checks++;
        if ({if_b.vec_out, if_b.busy, if_b.done, if_b.table_out} !== 21'h0) begin
            errors++;
            $display("FAIL reset_b: got %h expected 0",
                     {if_b.vec_out, if_b.busy, if_b.done, if_b.table_out});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Free-running sweep on u_a; noise=1 sprinkles ignored start/step pulses
    // and step_mode changes while busy.
    task automatic test_free_run_a(input logic [3:0] tbl, input bit noise);
        logic [15:0] p;
        logic [7:0]  exp;
        logic [7:0]  got;
        int          ev;
        func_a         = tbl;
        if_a.step_mode = 1'b0;
        if_a.start     = 1'b1;
        tick();
        if_a.start = 1'b0;
        checks++;
        got = {if_a.vec_out, if_a.busy, if_a.done, if_a.table_out};
        if (got !== 8'b00_1_0_0000) begin
            errors++;
            $display("FAIL free_start: got %b expected 00100000", got);
        end
        for (int c = 1; c <= 40; c++) begin
            if (noise) begin
                if_a.start     = ($urandom_range(0, 3) == 0);
                if_a.step      = ($urandom_range(0, 3) == 0);
                if_a.step_mode = 1'($urandom_range(0, 1));
            end
            tick();
            if_a.start = 1'b0;
            if_a.step  = 1'b0;
            ev  = (c >= 40) ? 3 : c / 10;
            p   = partial({12'h0, tbl}, (c / 10 > 4) ? 4 : c / 10, 1);
            exp = {2'(ev), (c < 40), (c >= 40), p[3:0]};
            got = {if_a.vec_out, if_a.busy, if_a.done, if_a.table_out};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL free_cycle%0d: got %b expected %b", c, got, exp);
            end
        end
        if_a.step_mode = 1'b0;
        repeat (3) tick();
        checks++;
        got = {if_a.vec_out, if_a.busy, if_a.done, if_a.table_out};
        if (got !== {2'd3, 1'b0, 1'b1, tbl}) begin
            errors++;
            $display("FAIL done_hold: got %b expected %b", got, {2'd3, 1'b0, 1'b1, tbl});
        end
    endtask

    task automatic test_step_mode(input logic [3:0] tbl);
        logic [15:0] p;
        logic [7:0]  exp;
        logic [7:0]  got;
        bit          last;
        func_a         = tbl;
        if_a.step_mode = 1'b1;
        if_a.start     = 1'b1;
        tick();
        if_a.start     = 1'b0;
        if_a.step_mode = 1'b0;  // mode is latched at start
        for (int v = 0; v < 4; v++) begin
            for (int c = 1; c <= 10; c++) begin
                if_a.step = ($urandom_range(0, 4) == 0);
                tick();
                if_a.step = 1'b0;
                last = (v == 3) && (c == 10);
                p    = partial({12'h0, tbl}, v + ((c == 10) ? 1 : 0), 1);
                exp  = {2'(v), !last, last, p[3:0]};
                got  = {if_a.vec_out, if_a.busy, if_a.done, if_a.table_out};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL step_v%0d_c%0d: got %b expected %b", v, c, got, exp);
                end
            end
            if (v < 3) begin
                p = partial({12'h0, tbl}, v + 1, 1);
                repeat ($urandom_range(0, 4)) begin
                    if_a.start = ($urandom_range(0, 1) == 0);
                    tick();
                    if_a.start = 1'b0;
                    got = {if_a.vec_out, if_a.busy, if_a.done, if_a.table_out};
                    checks++;
                    if (got !== {2'(v), 1'b1, 1'b0, p[3:0]}) begin
                        errors++;
                        $display("FAIL pause_v%0d: got %b expected %b", v, got,
                                 {2'(v), 1'b1, 1'b0, p[3:0]});
                    end
                end
                if_a.step = 1'b1;
                tick();
                if_a.step = 1'b0;
                got = {if_a.vec_out, if_a.busy, if_a.done, if_a.table_out};
                checks++;
                if (got !== {2'(v + 1), 1'b1, 1'b0, p[3:0]}) begin
                    errors++;
                    $display("FAIL step_adv_v%0d: got %b expected %b", v, got,
                             {2'(v + 1), 1'b1, 1'b0, p[3:0]});
                end
            end
        end
    endtask

    task automatic test_hold1_b(input logic [15:0] tbl);
        logic [15:0] p;
        logic [20:0] exp;
        logic [20:0] got;
        func_b     = tbl;
        if_b.start = 1'b1;
        tick();
        if_b.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            p   = partial(tbl, c, 2);
            exp = {3'((c >= 8) ? 7 : c), (c < 8), (c >= 8), p};
            got = {if_b.vec_out, if_b.busy, if_b.done, if_b.table_out};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL hold1_cycle%0d: got %h expected %h", c, got, exp);
            end
        end
    endtask

    task automatic test_popcount_b();
        logic [15:0] pc;
        for (int v = 0; v < 8; v++) pc[v*2 +: 2] = 2'($countones(3'(v)));
        test_hold1_b(pc);
        checks++;
        if ({if_b.table_out[15:14], if_b.table_out[1:0]} !== 4'b11_00) begin
            errors++;
            $display("FAIL popcount_slots: got %b expected 1100",
                     {if_b.table_out[15:14], if_b.table_out[1:0]});
        end
        test_hold1_b(16'($urandom));
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        func_a     = 4'($urandom);
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        repeat (23) tick();
        checks++;
        if (if_a.vec_out !== 2'd2) begin
            errors++;
            $display("FAIL mid_vec: got %0d expected 2", if_a.vec_out);
        end
        #2 rst = 1'b1;
        #1;
        got = {if_a.vec_out, if_a.busy, if_a.done, if_a.table_out};
        checks++;
        if (got !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %b expected 00000000", got);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_free_run_a(4'($urandom), 1'b0);
    endtask

    task automatic test_back_to_back();
        test_free_run_a(4'($urandom), 1'b1);
        test_free_run_a(4'($urandom), 1'b1);
    endtask

`ifdef TT_CHECK_EN
    task automatic test_check_en(input logic [3:0] golden, input logic [3:0] tbl);
        int exp_err;
        if_a.expected_in = golden;
        test_free_run_a(tbl, 1'b0);
        exp_err = $countones(golden ^ tbl);
        checks++;
        if ({if_a.err_count, if_a.mismatch} !== {3'(exp_err), exp_err != 0}) begin
            errors++;
            $display("FAIL err_count: got %0d/%b expected %0d/%b", if_a.err_count,
                     if_a.mismatch, exp_err, exp_err != 0);
        end
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        checks++;
        if ({if_a.err_count, if_a.mismatch} !== 4'b0) begin
            errors++;
            $display("FAIL err_clear: got %0d/%b expected 0/0", if_a.err_count,
                     if_a.mismatch);
        end
        repeat (40) tick();
    endtask
`endif

    initial begin
        if_a.start = 1'b0; if_a.step = 1'b0; if_a.step_mode = 1'b0;
        if_b.start = 1'b0; if_b.step = 1'b0; if_b.step_mode = 1'b0;
`ifdef TT_CHECK_EN
        if_a.expected_in = '0;
        if_b.expected_in = '0;
`endif
        test_reset();
        test_free_run_a(4'b1000, 1'b0);   // AND
        test_step_mode(4'b0110);          // XOR
        test_step_mode(4'($urandom));
        test_popcount_b();
        test_back_to_back();
        test_reset_mid();
`ifdef TT_CHECK_EN
        test_check_en(4'b1000, 4'b1110);  // golden AND, DUT OR
        test_check_en(4'($urandom), 4'($urandom));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
